// File: rtl/fifo_pkg.sv
// Shared FIFO defaults: depth, watermark levels and the per-cycle operation encoding.
// Pure declarations, no logic.
package fifo_pkg;

    localparam int FIFO_DEPTH_DEF  = 32;
    localparam int AEMPTY_LVL_DEF  = 4;
    localparam int AFULL_MARGIN    = 4;

    // {push_ok, pop_ok} viewed as one operation code
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/wrap_ptr.sv
// Modulo-DEPTH pointer: advances on en, zeroed by clear or reset; 1-cycle update.
// No backpressure; the caller gates en.
module wrap_ptr #(
    parameter int DEPTH = 32,
    parameter int WIDTH = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] ptr
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(DEPTH - 1);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller driving an external RAM; write port combinational, read valid 1 cycle after pop.
// Backpressure: push refused when full unless a pop frees a slot the same cycle; refused ops set sticky flags.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_DEPTH = FIFO_DEPTH_DEF,
    parameter int ADDR_WIDTH = $clog2(DATA_DEPTH),
    parameter int AFULL_LVL  = DATA_DEPTH - AFULL_MARGIN,
    parameter int AEMPTY_LVL = AEMPTY_LVL_DEF
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  afull_o,
    output logic                  aempty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  rd_valid_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    output logic                  mem_wr_en_o,
    output logic                  mem_wr_en_n_o,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr_o,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr_o
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DATA_DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_LVL);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LVL);
    localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;
    fifo_op_e              op;

    // Reset gates the strobes so the RAM sees no write while rstn_i is low.
    assign pop_ok  = rstn_i & ~clear_i & pop_i & ~empty_o;
    assign push_ok = rstn_i & ~clear_i & push_i & (~full_o | pop_ok);
    assign op      = fifo_op_e'({push_ok, pop_ok});

    assign full_o   = (count == DEPTH_C);
    assign empty_o  = (count == '0);
    assign afull_o  = (count >= AFULL_C);
    assign aempty_o = (count <= AEMPTY_C);
    assign count_o  = count;

    assign mem_wr_en_o   = push_ok;
    assign mem_wr_en_n_o = ~push_ok;
    assign mem_wr_addr_o = wr_ptr;
    assign mem_rd_addr_o = rd_ptr;

    wrap_ptr #(.DEPTH(DATA_DEPTH), .WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clear  (clear_i),
        .en     (push_ok),
        .ptr    (wr_ptr)
    );

    wrap_ptr #(.DEPTH(DATA_DEPTH), .WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clear  (clear_i),
        .en     (pop_ok),
        .ptr    (rd_ptr)
    );

    always_comb begin
        count_nxt = count;
        unique case (op)
            OP_PUSH: count_nxt = count + ONE_C;
            OP_POP:  count_nxt = count - ONE_C;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count       <= '0;
            rd_valid_o  <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (clear_i) begin
            count       <= '0;
            rd_valid_o  <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            count      <= count_nxt;
            rd_valid_o <= pop_ok;
            if (push_i && !push_ok) overflow_o  <= 1'b1;
            if (pop_i && empty_o)   underflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: reference model plus data scoreboard over a behavioural synchronous RAM.
module tb_sync_fifo_ctrl;

    localparam int D   = 32;
    localparam int AW  = 5;
    localparam int AFL = 28;
    localparam int AEL = 4;

    logic          clk_i = 1'b0;
    logic          rstn_i, clear_i, push_i, pop_i;
    logic          full_o, empty_o, afull_o, aempty_o;
    logic [AW:0]   count_o;
    logic          rd_valid_o, overflow_o, underflow_o;
    logic          mem_wr_en_o, mem_wr_en_n_o;
    logic [AW-1:0] mem_wr_addr_o, mem_rd_addr_o;

    sync_fifo_ctrl #(.DATA_DEPTH(D)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .clear_i       (clear_i),
        .push_i        (push_i),
        .pop_i         (pop_i),
        .full_o        (full_o),
        .empty_o       (empty_o),
        .afull_o       (afull_o),
        .aempty_o      (aempty_o),
        .count_o       (count_o),
        .rd_valid_o    (rd_valid_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o),
        .mem_wr_en_o   (mem_wr_en_o),
        .mem_wr_en_n_o (mem_wr_en_n_o),
        .mem_wr_addr_o (mem_wr_addr_o),
        .mem_rd_addr_o (mem_rd_addr_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural RAM with a registered read port
    logic [7:0] tb_mem [D];
    logic [7:0] wdata = 8'h00;
    logic [7:0] rd_data_q;
    always @(posedge clk_i) begin
        if (mem_wr_en_o) tb_mem[mem_wr_addr_o] <= wdata;
        rd_data_q <= tb_mem[mem_rd_addr_o];
    end

    int n_vec = 0;
    int n_err = 0;
    int n_rd  = 0;

    int   m_count, m_wp, m_rp;
    logic m_ovf, m_udf, m_rvld;
    logic [7:0] sb_q [$];
    logic [7:0] data_ctr = 8'h00;
    logic wr_en_seen;

    typedef struct {
        logic       push, pop, clear;
        logic [5:0] count;
        logic       full, empty, afull, aempty, ovf, udf, wr_en;
    } vec_t;
    vec_t vt [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_wp = 0; m_rp = 0;
        m_ovf = 1'b0; m_udf = 1'b0; m_rvld = 1'b0;
        sb_q.delete();
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"},  32'(count_o),  32'(m_count));
        chk({tag, ".full"},   32'(full_o),   32'(m_count == D));
        chk({tag, ".empty"},  32'(empty_o),  32'(m_count == 0));
        chk({tag, ".afull"},  32'(afull_o),  32'(m_count >= AFL));
        chk({tag, ".aempty"}, 32'(aempty_o), 32'(m_count <= AEL));
        chk({tag, ".ovf"},    32'(overflow_o),  32'(m_ovf));
        chk({tag, ".udf"},    32'(underflow_o), 32'(m_udf));
        chk({tag, ".rvld"},   32'(rd_valid_o),  32'(m_rvld));
    endtask

    // One clock: drive at negedge, check write port before the edge, state after it.
    task automatic cycle(input logic pu, input logic po, input logic cl);
        logic exp_pop, exp_push;
        data_ctr = data_ctr + 8'd1;
        wdata    = data_ctr;
        push_i = pu; pop_i = po; clear_i = cl;
        exp_pop  = po && (m_count != 0) && !cl;
        exp_push = pu && !cl && ((m_count != D) || exp_pop);
        #1;
        wr_en_seen = mem_wr_en_o;
        chk("mem_wr_en",   32'(mem_wr_en_o),   32'(exp_push));
        chk("mem_wr_en_n", 32'(mem_wr_en_n_o), 32'(!exp_push));
        if (exp_push) chk("mem_wr_addr", 32'(mem_wr_addr_o), 32'(m_wp));
        if (exp_pop)  chk("mem_rd_addr", 32'(mem_rd_addr_o), 32'(m_rp));
        if (cl) begin
            model_reset();
        end else begin
            if (pu && !exp_push)     m_ovf = 1'b1;
            if (po && m_count == 0)  m_udf = 1'b1;
            if (exp_push) begin sb_q.push_back(wdata); m_wp = (m_wp + 1) % D; end
            if (exp_pop)  m_rp = (m_rp + 1) % D;
            m_count = m_count + (exp_push ? 1 : 0) - (exp_pop ? 1 : 0);
            m_rvld  = exp_pop;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        check_state("cyc");
        if (rd_valid_o === 1'b1) begin
            n_rd++;
            if (sb_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
            else                  chk("rd_data", 32'(rd_data_q), 32'(sb_q.pop_front()));
        end
    endtask

    initial begin
        vt[0] = '{1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b1, 1'b0, 6'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[2] = '{1'b1, 1'b0, 1'b0, 6'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[3] = '{1'b1, 1'b0, 1'b0, 6'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[4] = '{1'b1, 1'b0, 1'b0, 6'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[5] = '{1'b1, 1'b0, 1'b0, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[6] = '{1'b1, 1'b0, 1'b1, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[7] = '{1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[8] = '{1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        rstn_i = 1'b0; clear_i = 1'b0; push_i = 1'b0; pop_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        check_state("reset");
        chk("reset.wr_en",   32'(mem_wr_en_o),   32'd0);
        chk("reset.wr_en_n", 32'(mem_wr_en_n_o), 32'd1);
        rstn_i = 1'b1;
        @(negedge clk_i);

        // Fill to full; watermark and pointer wrap
        for (int i = 0; i < D; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (i == 26) chk("fill.afull_at27", 32'(afull_o), 32'd0);
            if (i == 27) chk("fill.afull_at28", 32'(afull_o), 32'd1);
        end
        chk("fill.full",    32'(full_o),        32'd1);
        chk("fill.count",   32'(count_o),       32'd32);
        chk("fill.wr_wrap", 32'(mem_wr_addr_o), 32'd0);

        cycle(1'b1, 1'b0, 1'b0);
        chk("ovf.no_write", 32'(wr_en_seen),  32'd0);
        chk("ovf.flag",     32'(overflow_o),  32'd1);
        chk("ovf.count",    32'(count_o),     32'd32);

        cycle(1'b1, 1'b1, 1'b0);
        chk("full_pp.write", 32'(wr_en_seen), 32'd1);
        chk("full_pp.count", 32'(count_o),    32'd32);
        chk("full_pp.ovf",   32'(overflow_o), 32'd1);

        // Drain; scoreboard checks data order
        for (int i = 0; i < D; i++) cycle(1'b0, 1'b1, 1'b0);
        chk("drain.empty", 32'(empty_o), 32'd1);
        chk("drain.reads", 32'(n_rd),    32'd33);

        cycle(1'b0, 1'b1, 1'b0);
        chk("extra_pop.udf",  32'(underflow_o), 32'd1);
        chk("extra_pop.rvld", 32'(rd_valid_o),  32'd0);

        // Table: clear, push+pop at empty, clear with push at count 5, underflow
        for (int i = 0; i < 9; i++) begin
            cycle(vt[i].push, vt[i].pop, vt[i].clear);
            chk($sformatf("vec%0d.count", i),  32'(count_o),     32'(vt[i].count));
            chk($sformatf("vec%0d.full", i),   32'(full_o),      32'(vt[i].full));
            chk($sformatf("vec%0d.empty", i),  32'(empty_o),     32'(vt[i].empty));
            chk($sformatf("vec%0d.afull", i),  32'(afull_o),     32'(vt[i].afull));
            chk($sformatf("vec%0d.aempty", i), 32'(aempty_o),    32'(vt[i].aempty));
            chk($sformatf("vec%0d.ovf", i),    32'(overflow_o),  32'(vt[i].ovf));
            chk($sformatf("vec%0d.udf", i),    32'(underflow_o), 32'(vt[i].udf));
            chk($sformatf("vec%0d.wr_en", i),  32'(wr_en_seen),  32'(vt[i].wr_en));
        end

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0);
        chk("burst.count", 32'(count_o), 32'd10);
        push_i = 1'b1; pop_i = 1'b0; clear_i = 1'b0;
        #2 rstn_i = 1'b0;
        #1;
        chk("arst.count",  32'(count_o),       32'd0);
        chk("arst.empty",  32'(empty_o),       32'd1);
        chk("arst.aempty", 32'(aempty_o),      32'd1);
        chk("arst.full",   32'(full_o),        32'd0);
        chk("arst.afull",  32'(afull_o),       32'd0);
        chk("arst.wr_en",  32'(mem_wr_en_o),   32'd0);
        chk("arst.wr_en_n",32'(mem_wr_en_n_o), 32'd1);
        chk("arst.rvld",   32'(rd_valid_o),    32'd0);
        chk("arst.ovf",    32'(overflow_o),    32'd0);
        chk("arst.udf",    32'(underflow_o),   32'd0);
        push_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        model_reset();
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_DEPTH, default 32: number of memory entries, power of two, at least 4.
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(DATA_DEPTH): memory address width.
REQ-003 SHALL have parameter AFULL_LVL, default DATA_DEPTH-4: almost-full threshold.
REQ-004 SHALL have parameter AEMPTY_LVL, default 4: almost-empty threshold.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  sole clock; rstn_i  in  1  reset.
REQ-006 SHALL have these ports:
- clear_i  in  1  synchronous flush.
- push_i  in  1  write request.
- pop_i  in  1  read request.
- full_o  out  1
- empty_o  out  1
- afull_o  out  1
- aempty_o  out  1
- count_o  out  ADDR_WIDTH+1  occupancy.
- rd_valid_o  out  1  memory read data valid this cycle.
- overflow_o  out  1  sticky error flag.
- underflow_o  out  1  sticky error flag.
- mem_wr_en_o  out  1  memory write enable, active high.
- mem_wr_en_n_o  out  1  memory write enable, active low.
- mem_wr_addr_o  out  ADDR_WIDTH
- mem_rd_addr_o  out  ADDR_WIDTH

Function
REQ-007 SHALL accept a pop (pop_ok) when pop_i=1 and empty_o=0.
REQ-008 SHALL accept a push (push_ok) when push_i=1 and either full_o=0 or pop_ok=1 (push and pop together while full is legal).
REQ-009 SHALL drive the memory write port combinationally: mem_wr_en_o=push_ok, mem_wr_en_n_o=~push_ok, mem_wr_addr_o=wr_ptr.
REQ-010 SHALL drive mem_rd_addr_o=rd_ptr combinationally, and SHALL register rd_valid_o<=pop_ok, so data is valid exactly 1 cycle after an accepted pop.
REQ-011 SHALL increment wr_ptr on push_ok and rd_ptr on pop_ok, with modulo-DATA_DEPTH wrap from DATA_DEPTH-1 to 0.
REQ-012 SHALL update count as: +1 on push only, -1 on pop only, unchanged on both or neither; range is 0..DATA_DEPTH.
REQ-013 SHALL derive the status outputs from the registered count: full_o=(count==DATA_DEPTH), empty_o=(count==0), afull_o=(count>=AFULL_LVL), aempty_o=(count<=AEMPTY_LVL).
REQ-014 SHALL set overflow_o on push_i=1 with push rejected, and underflow_o on pop_i=1 with empty_o=1; both SHALL hold until clear_i or reset.
REQ-015 SHALL, when clear_i=1, zero pointers, count, rd_valid_o and error flags at the next edge, and SHALL suppress push_ok and pop_ok in that cycle.
REQ-016 SHALL, for push while empty with pop in the same cycle, reject the pop (underflow set), accept the push, and set count=1.

Reset
REQ-017 SHALL, while rstn_i=0, asynchronously set wr_ptr=0, rd_ptr=0, count=0, rd_valid_o=0, overflow_o=0, underflow_o=0; hence empty_o=1, aempty_o=1, full_o=0, afull_o=0, mem_wr_en_o=0, mem_wr_en_n_o=1.
REQ-018 SHALL, on reset mid-operation, discard all stored occupancy; memory contents are not used after reset.

Structure
REQ-019 SHALL take default depth and threshold constants from shared package fifo_pkg.
REQ-020 SHALL implement each pointer as one sub-module wrap_ptr (enable, clear, modulo-DATA_DEPTH increment), instantiated twice.

Verification
REQ-021 Bench SHALL drive reset, then 32 pushes -> count 32, full_o=1 after the 32nd push, afull_o=1 from count 28, wr_ptr wrapped to 0.
REQ-022 Bench SHALL drive 1 push while full -> overflow_o=1, count stays 32, mem_wr_en_o=0; 1 push+pop while full -> both accepted, count 32, overflow_o remains 1.
REQ-023 Bench SHALL drive 32 pops -> rd_valid_o=1 one cycle after each pop, read data in push order, empty_o=1 after the last pop; an extra pop -> underflow_o=1, rd_valid_o=0.
REQ-024 Bench SHALL drive simultaneous push+pop at count 0 -> count 1, underflow_o=1, mem_wr_en_o=1 at address 0.
REQ-025 Bench SHALL assert clear_i together with push_i at count 5 -> next cycle count 0, empty_o=1, flags 0, no write.
REQ-026 Bench SHALL drop rstn_i asynchronously mid-burst at count 10 -> outputs take reset values immediately without a clock edge.
